// File: rtl/aud_pkg.sv
// ============================================================================
// Module   : aud_pkg
// Purpose  : Shared types and constants for the audio elapsed-time display
//            path (sample count -> seconds -> two BCD digits).
// Contents : state_e             - converter FSM state encoding
//            SAMPLE_RATE_DEFAULT - samples per second per SRAM word
//            BCD_STEPS           - shift steps for a 7-bit double-dabble
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package aud_pkg;

  localparam int SAMPLE_RATE_DEFAULT = 32000;
  localparam int BCD_STEPS           = 7;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_DIV  = 3'd1,
    ST_SAT  = 3'd2,
    ST_BCD  = 3'd3,
    ST_DONE = 3'd4
  } state_e;

endpackage

`default_nettype wire

// File: rtl/bcd_dabble7.sv
// ============================================================================
// Module   : bcd_dabble7
// Purpose  : Serial double-dabble converter, 7-bit binary (0..99) to two
//            BCD digits, one shift per step.
// Ports    : clk_i, rst_i  - clock, synchronous active-high reset
//            load_i        - load value_i, clear digits and step count
//            value_i[6:0]  - binary value to convert
//            step_i        - perform one add-3/shift step
//            tens_o/ones_o - BCD digits (valid after BCD_STEPS steps)
//            last_o        - the step applied this cycle is the final one
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_dabble7
  import aud_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       load_i,
  input  logic [6:0] value_i,
  input  logic       step_i,
  output logic [3:0] tens_o,
  output logic [3:0] ones_o,
  output logic       last_o
);

  localparam int c_CNT_W = $clog2(BCD_STEPS + 1);

  logic [6:0]         sr_q,   sr_d;
  logic [3:0]         tens_q, tens_d;
  logic [3:0]         ones_q, ones_d;
  logic [c_CNT_W-1:0] cnt_q,  cnt_d;

  logic [3:0] w_tens_adj;
  logic [3:0] w_ones_adj;
  logic       w_done;

  assign w_done     = (cnt_q == c_CNT_W'(BCD_STEPS));
  assign w_tens_adj = (tens_q >= 4'd5) ? tens_q + 4'd3 : tens_q;
  assign w_ones_adj = (ones_q >= 4'd5) ? ones_q + 4'd3 : ones_q;

  always_comb begin
    sr_d   = sr_q;
    tens_d = tens_q;
    ones_d = ones_q;
    cnt_d  = cnt_q;
    if (load_i) begin
      sr_d   = value_i;
      tens_d = 4'd0;
      ones_d = 4'd0;
      cnt_d  = '0;
    end else if (step_i && !w_done) begin
      // Adjusted nibbles and the binary register shift left as one chain.
      tens_d = {w_tens_adj[2:0], w_ones_adj[3]};
      ones_d = {w_ones_adj[2:0], sr_q[6]};
      sr_d   = {sr_q[5:0], 1'b0};
      cnt_d  = cnt_q + c_CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sr_q   <= '0;
      tens_q <= '0;
      ones_q <= '0;
      cnt_q  <= '0;
    end else begin
      sr_q   <= sr_d;
      tens_q <= tens_d;
      ones_q <= ones_d;
      cnt_q  <= cnt_d;
    end
  end

  assign tens_o = tens_q;
  assign ones_o = ones_q;
  assign last_o = step_i && !load_i && (cnt_q == c_CNT_W'(BCD_STEPS - 1));

endmodule

`default_nettype wire

// File: rtl/aud_time_bcd.sv
// ============================================================================
// Module   : aud_time_bcd
// Purpose  : Converts a recorder sample count into elapsed whole seconds
//            (truncated, saturated at SEC_MAX) shown as two BCD digits.
//            Restoring divider, one quotient bit per cycle, then a serial
//            double-dabble. Fixed latency of ADDR_W + 9 cycles.
// Ports    : i_clk, i_rst   - clock, synchronous active-high reset
//            i_start        - single-cycle request, samples i_count in IDLE
//            i_count        - sample count to convert
//            o_busy         - conversion in progress
//            o_valid        - one-cycle pulse when new digits are written
//            o_sec_tens/ones- BCD seconds digits (held between conversions)
//            o_ovf          - quotient exceeded SEC_MAX, digits saturated
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module aud_time_bcd
  import aud_pkg::*;
#(
  parameter int ADDR_W      = 20,
  parameter int SAMPLE_RATE = SAMPLE_RATE_DEFAULT,
  parameter int SEC_MAX     = 99
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_count,
  output logic              o_busy,
  output logic              o_valid,
  output logic [3:0]        o_sec_tens,
  output logic [3:0]        o_sec_ones,
  output logic              o_ovf
);

  // One extra bit so the shifted-in remainder never overflows before compare.
  localparam int                c_REM_W = $clog2(SAMPLE_RATE) + 1;
  localparam int                c_CNT_W = $clog2(ADDR_W + 1);
  localparam logic [c_REM_W-1:0] c_RATE  = c_REM_W'(SAMPLE_RATE);

  state_e state_q, state_d;

  logic [ADDR_W-1:0]  div_q;      // dividend, refilled with quotient bits
  logic [c_REM_W-1:0] rem_q;
  logic [c_CNT_W-1:0] cnt_q;
  logic               ovf_work_q;
  logic               busy_q, valid_q, ovf_q;
  logic [3:0]         tens_q, ones_q;

  logic               w_accept, w_div_en, w_sat_en, w_bcd_en, w_done_en;
  logic [c_REM_W-1:0] w_rem_sh, w_rem_nx;
  logic               w_ge, w_over;
  logic [6:0]         w_sat_val;
  logic [3:0]         w_dab_tens, w_dab_ones;
  logic               w_dab_last;

  // Restoring divide step.
  assign w_rem_sh = {rem_q[c_REM_W-2:0], div_q[ADDR_W-1]};
  assign w_ge     = (w_rem_sh >= c_RATE);
  assign w_rem_nx = w_ge ? (w_rem_sh - c_RATE) : w_rem_sh;

  // Saturation of the finished quotient.
  assign w_over    = (div_q > ADDR_W'(SEC_MAX));
  assign w_sat_val = w_over ? 7'(SEC_MAX) : div_q[6:0];

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (i_start) state_d = ST_DIV;
      ST_DIV:  if (cnt_q == c_CNT_W'(ADDR_W - 1)) state_d = ST_SAT;
      ST_SAT:  state_d = ST_BCD;
      ST_BCD:  if (w_dab_last) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Per-state control strobes.
  always_comb begin
    w_accept  = 1'b0;
    w_div_en  = 1'b0;
    w_sat_en  = 1'b0;
    w_bcd_en  = 1'b0;
    w_done_en = 1'b0;
    case (state_q)
      ST_IDLE: w_accept  = i_start;
      ST_DIV:  w_div_en  = 1'b1;
      ST_SAT:  w_sat_en  = 1'b1;
      ST_BCD:  w_bcd_en  = 1'b1;
      ST_DONE: w_done_en = 1'b1;
      default: ;
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      div_q      <= '0;
      rem_q      <= '0;
      cnt_q      <= '0;
      ovf_work_q <= 1'b0;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
      ovf_q      <= 1'b0;
      tens_q     <= '0;
      ones_q     <= '0;
    end else begin
      valid_q <= w_done_en;
      if (w_accept) begin
        div_q  <= i_count;
        rem_q  <= '0;
        cnt_q  <= '0;
        busy_q <= 1'b1;
      end
      if (w_div_en) begin
        rem_q <= w_rem_nx;
        div_q <= {div_q[ADDR_W-2:0], w_ge};
        cnt_q <= cnt_q + c_CNT_W'(1);
      end
      if (w_sat_en) ovf_work_q <= w_over;
      if (w_done_en) begin
        tens_q <= w_dab_tens;
        ones_q <= w_dab_ones;
        ovf_q  <= ovf_work_q;
        busy_q <= 1'b0;
      end
    end
  end

  bcd_dabble7 u_dabble (
    .clk_i   (i_clk),
    .rst_i   (i_rst),
    .load_i  (w_sat_en),
    .value_i (w_sat_val),
    .step_i  (w_bcd_en),
    .tens_o  (w_dab_tens),
    .ones_o  (w_dab_ones),
    .last_o  (w_dab_last)
  );

  assign o_busy     = busy_q;
  assign o_valid    = valid_q;
  assign o_sec_tens = tens_q;
  assign o_sec_ones = ones_q;
  assign o_ovf      = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_aud_time_bcd.sv
// ============================================================================
// Module   : tb_aud_time_bcd
// Purpose  : Self-checking bench for aud_time_bcd at the default 32000 rate
//            and at an 8000 rate (to reach the saturation path).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_aud_time_bcd;

  localparam int LAT = 29;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  start = 2'b00;
  logic [19:0] count0 = '0;
  logic [19:0] count1 = '0;
  logic [1:0]  busy_w, valid_w, ovf_w;
  logic [3:0]  tens_w [2];
  logic [3:0]  ones_w [2];

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  aud_time_bcd dut (
    .i_clk(clk), .i_rst(rst), .i_start(start[0]), .i_count(count0),
    .o_busy(busy_w[0]), .o_valid(valid_w[0]), .o_sec_tens(tens_w[0]),
    .o_sec_ones(ones_w[0]), .o_ovf(ovf_w[0])
  );

  aud_time_bcd #(.SAMPLE_RATE(8000)) dut8k (
    .i_clk(clk), .i_rst(rst), .i_start(start[1]), .i_count(count1),
    .o_busy(busy_w[1]), .o_valid(valid_w[1]), .o_sec_tens(tens_w[1]),
    .o_sec_ones(ones_w[1]), .o_ovf(ovf_w[1])
  );

  // Seconds = floor(count / rate), clamped at 99; returns {ovf, tens, ones}.
  function automatic logic [8:0] expect_digits(int cnt, int rate);
    int q, v;
    logic ov;
    q  = cnt / rate;
    ov = (q > 99);
    v  = ov ? 99 : q;
    return {ov, 4'(v / 10), 4'(v % 10)};
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: a request accepted when idle produces its
  // result exactly LAT edges later; requests while busy are dropped.
  int         m_timer [2];
  logic       m_busy  [2];
  logic       m_valid [2];
  logic [8:0] m_res   [2];
  logic [8:0] p_res   [2];

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_busy[i]  <= 1'b0;
        m_valid[i] <= 1'b0;
        m_timer[i] <= 0;
        m_res[i]   <= '0;
        p_res[i]   <= '0;
      end else begin
        m_valid[i] <= 1'b0;
        if (m_busy[i]) begin
          if (m_timer[i] == LAT - 1) begin
            m_busy[i]  <= 1'b0;
            m_valid[i] <= 1'b1;
            m_res[i]   <= p_res[i];
          end
          m_timer[i] <= m_timer[i] + 1;
        end else if (start[i]) begin
          m_busy[i]  <= 1'b1;
          m_timer[i] <= 0;
          p_res[i]   <= (i == 0) ? expect_digits(int'(count0), 32000)
                                 : expect_digits(int'(count1), 8000);
        end
      end
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("busy[%0d]", i),  int'(busy_w[i]),  int'(m_busy[i]));
        chk($sformatf("valid[%0d]", i), int'(valid_w[i]), int'(m_valid[i]));
        chk($sformatf("tens[%0d]", i),  int'(tens_w[i]),  int'(m_res[i][7:4]));
        chk($sformatf("ones[%0d]", i),  int'(ones_w[i]),  int'(m_res[i][3:0]));
        chk($sformatf("ovf[%0d]", i),   int'(ovf_w[i]),   int'(m_res[i][8]));
      end
    end
  end

  task automatic pulse_start(input int idx, input int cnt);
    @(negedge clk);
    start[idx] = 1'b1;
    if (idx == 0) count0 = 20'(cnt);
    else          count1 = 20'(cnt);
    @(posedge clk);
    #1 start[idx] = 1'b0;
  endtask

  task automatic do_conv(input int idx, input int cnt, input int et,
                         input int eo, input int eov, input string name);
    int lat;
    lat = 0;
    pulse_start(idx, cnt);
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk);
      #1;
      if (valid_w[idx] && lat == 0) lat = c;
      if (lat != 0) break;
    end
    chk({name, "_latency"}, lat, LAT);
    chk({name, "_tens"}, int'(tens_w[idx]), et);
    chk({name, "_ones"}, int'(ones_w[idx]), eo);
    chk({name, "_ovf"},  int'(ovf_w[idx]),  eov);
  endtask

  task automatic count_valids(input int idx, input int cycles, output int n);
    n = 0;
    for (int c = 0; c < cycles; c++) begin
      @(posedge clk);
      #1;
      if (valid_w[idx]) n++;
    end
  endtask

  initial begin
    int n;

    // Model pinned against hand-computed values.
    chk("model_32s",  int'(expect_digits(1048575, 32000)), int'({1'b0, 4'd3, 4'd2}));
    chk("model_131s", int'(expect_digits(1048575, 8000)),  int'({1'b1, 4'd9, 4'd9}));

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    chk("reset_busy",  int'(busy_w[0]),  0);
    chk("reset_valid", int'(valid_w[0]), 0);
    chk("reset_tens",  int'(tens_w[0]),  0);
    chk("reset_ones",  int'(ones_w[0]),  0);
    chk("reset_ovf",   int'(ovf_w[0]),   0);

    do_conv(0, 0,       0, 0, 0, "zero");
    do_conv(0, 31999,   0, 0, 0, "c31999");
    do_conv(0, 32000,   0, 1, 0, "c32000");
    do_conv(0, 320000,  1, 0, 0, "c320000");
    do_conv(0, 792000,  2, 4, 0, "c792000");
    do_conv(0, 1048575, 3, 2, 0, "cmax");

    do_conv(1, 1048575, 9, 9, 1, "r8k_max");
    do_conv(1, 792000,  9, 9, 0, "r8k_99s");
    do_conv(1, 800000,  9, 9, 1, "r8k_100s");
    do_conv(1, 7999,    0, 0, 0, "r8k_7999");

    // A second request while busy must be dropped.
    pulse_start(0, 160000);
    repeat (4) @(posedge clk);
    pulse_start(0, 640000);
    count_valids(0, 40, n);
    chk("busy_req_valids", n, 1);
    chk("busy_req_tens", int'(tens_w[0]), 0);
    chk("busy_req_ones", int'(ones_w[0]), 5);

    // Restore a nonzero result so the reset clear is visible.
    do_conv(0, 1048575, 3, 2, 0, "pre_rst");

    // Reset 10 cycles into the divide.
    pulse_start(0, 320000);
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    chk("abort_busy", int'(busy_w[0]), 0);
    chk("abort_tens", int'(tens_w[0]), 0);
    chk("abort_ones", int'(ones_w[0]), 0);
    count_valids(0, 35, n);
    chk("abort_no_valid", n, 0);
    do_conv(0, 320000, 1, 0, 0, "post_rst");

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
